// File: rtl/adder_result_accumulator_if.sv
// Handshake bundle between the N-bit adder, the result accumulator and its consumer.
// The upstream side carries {cout, sum}; the downstream side carries the accumulated total.
interface adder_result_accumulator_if #(
    parameter int N     = 8,
    parameter int ACC_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_sum;
    logic             in_cout;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_ovf;

    modport master (
        output in_valid, in_sum, in_cout, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf
    );

    modport slave (
        input  in_valid, in_sum, in_cout, out_ready,
        output in_ready, out_valid, out_acc, out_ovf
    );
endinterface

// File: rtl/adder_result_accumulator.sv
// Accumulates COUNT adder results ({cout,sum}) into an ACC_W-bit total with sticky overflow.
// Define SATURATE_EN to clamp the total at all-ones on overflow instead of wrapping.
module adder_result_accumulator #(
    parameter int N     = 8,
    parameter int ACC_W = 16,
    parameter int COUNT = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    adder_result_accumulator_if.slave   bus,
    output logic                        busy
);
    localparam int CNT_W = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic             accept;
    logic [ACC_W-1:0] operand;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] acc_next;

    assign accept  = bus.in_valid & bus.in_ready;
    assign operand = ACC_W'({bus.in_cout, bus.in_sum});
    assign sum_ext = {1'b0, acc} + {1'b0, operand};

    // Once clamped, acc is all-ones, so any non-zero operand carries again and stays clamped.
`ifdef SATURATE_EN
    assign acc_next = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign acc_next = sum_ext[ACC_W-1:0];
`endif

    assign bus.out_acc = acc;
    assign bus.out_ovf = ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            acc           <= '0;
            cnt           <= '0;
            ovf           <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b0;
            busy          <= 1'b0;
        end else if (clear) begin
            state         <= IDLE;
            acc           <= '0;
            cnt           <= '0;
            ovf           <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.in_ready <= 1'b1;
                    if (accept) begin
                        acc  <= operand;
                        cnt  <= CNT_W'(1);
                        ovf  <= 1'b0;
                        busy <= 1'b1;
                        if (COUNT == 1) begin
                            state         <= HOLD;
                            bus.out_valid <= 1'b1;
                            bus.in_ready  <= 1'b0;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= acc_next;
                        cnt <= cnt + CNT_W'(1);
                        ovf <= ovf | sum_ext[ACC_W];
                        if (cnt == LAST_CNT) begin
                            state         <= HOLD;
                            bus.out_valid <= 1'b1;
                            bus.in_ready  <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        acc           <= '0;
                        cnt           <= '0;
                        ovf           <= 1'b0;
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        busy          <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    busy          <= 1'b0;
                end
            endcase
        end
    end
endmodule
